// File: rtl/inst_loader_if.sv
// Write/readback port between the instruction loader and the 64x32 instruction store.
// master = loader (drives write side), slave = memory (returns synchronous read data).
interface inst_loader_if;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    modport master (output mem_we, output mem_addr, output mem_din, input mem_dout);
    modport slave  (input mem_we, input mem_addr, input mem_din, output mem_dout);
endinterface

// File: rtl/inst_loader.sv
// Debounced button loads Sw bytes little-endian into 32-bit words written at auto-incrementing addresses.
// Latency: press 9 clk after stable Btn rise; write 1 clk after 4th byte (INST_LOADER_READBACK_EN adds READ/CHECK).
// No backpressure: presses outside COLLECT or after full are dropped.
module inst_loader (
    input  logic              clk,
    input  logic              Rst,
    input  logic              Btn,
    input  logic [7:0]        Sw,
    inst_loader_if.master     mem,
    output logic [7:0]        LED,
    output logic              full,
    output logic              err
);

`ifdef INST_LOADER_READBACK_EN
    typedef enum logic [1:0] {COLLECT, WRITE, READ, CHECK} state_t;
`else
    typedef enum logic {COLLECT, WRITE} state_t;
`endif

    state_t      state;
    logic [7:0]  btn_sr;
    logic        btn_lvl;
    logic        press;
    logic [1:0]  byte_idx;
    logic [23:0] word_lo;   // lanes 0..2; lane 3 comes straight from Sw at the final capture

    assign press = (btn_sr == 8'hFF) && !btn_lvl;
    assign LED   = {byte_idx, mem.mem_addr};

`ifndef INST_LOADER_READBACK_EN
    logic unused_dout;
    assign unused_dout = ^mem.mem_dout;
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (Rst) begin
            state        <= COLLECT;
            btn_sr       <= 8'h00;
            btn_lvl      <= 1'b0;
            byte_idx     <= 2'd0;
            word_lo      <= 24'h0;
            mem.mem_we   <= 1'b0;
            mem.mem_addr <= 6'd0;
            mem.mem_din  <= 32'h0;
            full         <= 1'b0;
`ifdef INST_LOADER_READBACK_EN
            err          <= 1'b0;
`endif
        end else begin
            btn_sr <= {btn_sr[6:0], Btn};
            if (press)
                btn_lvl <= 1'b1;
            else if (btn_sr == 8'h00)
                btn_lvl <= 1'b0;

            case (state)
                COLLECT: begin
                    if (press && !full) begin
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word_lo[7:0]   <= Sw;
                            2'd1: word_lo[15:8]  <= Sw;
                            2'd2: word_lo[23:16] <= Sw;
                            2'd3: begin
                                mem.mem_din <= {Sw, word_lo};
                                mem.mem_we  <= 1'b1;
                                state       <= WRITE;
                            end
                        endcase
                    end
                end
`ifdef INST_LOADER_READBACK_EN
                WRITE: begin
                    mem.mem_we <= 1'b0;
                    state      <= READ;
                end
                READ: state <= CHECK;
                CHECK: begin
                    if (mem.mem_dout != mem.mem_din)
                        err <= 1'b1;
                    if (mem.mem_addr == 6'd63)
                        full <= 1'b1;
                    mem.mem_addr <= mem.mem_addr + 6'd1;
                    state        <= COLLECT;
                end
`else
                WRITE: begin
                    mem.mem_we <= 1'b0;
                    if (mem.mem_addr == 6'd63)
                        full <= 1'b1;
                    mem.mem_addr <= mem.mem_addr + 6'd1;
                    state        <= COLLECT;
                end
`endif
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: table of words plus bounce, reset, full and readback sequences.
module tb_inst_loader;
    logic       clk = 1'b0;
    logic       Rst;
    logic       Btn;
    logic [7:0] Sw;
    logic [7:0] LED;
    logic       full;
    logic       err;
    logic       corrupt;

    always #5 clk = ~clk;

    inst_loader_if mem_bus ();

    inst_loader dut (
        .clk  (clk),
        .Rst  (Rst),
        .Btn  (Btn),
        .Sw   (Sw),
        .mem  (mem_bus),
        .LED  (LED),
        .full (full),
        .err  (err)
    );

    // Instruction store model: synchronous write, synchronous read-old
    logic [31:0] model_mem [0:63];
    always @(posedge clk) begin
        if (mem_bus.mem_we)
            model_mem[mem_bus.mem_addr] <= mem_bus.mem_din;
        mem_bus.mem_dout <= corrupt ? 32'hDEADBEEF : model_mem[mem_bus.mem_addr];
    end

    int          we_cnt = 0;
    logic [5:0]  we_addr = 6'd0;
    logic [31:0] we_din = 32'h0;
    always @(negedge clk) begin
        if (mem_bus.mem_we === 1'b1) begin
            we_cnt++;
            we_addr = mem_bus.mem_addr;
            we_din  = mem_bus.mem_din;
        end
    end

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk); #1 Rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1 Rst = 1'b0;
    endtask

    task automatic press_byte(input logic [7:0] b);
        @(posedge clk); #1 Sw = b; Btn = 1'b1;
        repeat (10) @(posedge clk);
        #1 Btn = 1'b0;
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic press_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++)
            press_byte(w[8*k +: 8]);
    endtask

    typedef struct {
        logic [31:0] word;
        logic [5:0]  exp_addr;
        logic [7:0]  exp_led;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int c0;
        vecs[0] = '{word: 32'h00100513, exp_addr: 6'd0, exp_led: 8'h01};
        vecs[1] = '{word: 32'hDEADBEEF, exp_addr: 6'd1, exp_led: 8'h02};
        vecs[2] = '{word: 32'h00000000, exp_addr: 6'd2, exp_led: 8'h03};
        vecs[3] = '{word: 32'hFFFFFFFF, exp_addr: 6'd3, exp_led: 8'h04};

        Rst = 1'b1; Btn = 1'b0; Sw = 8'h00; corrupt = 1'b0;
        repeat (3) @(posedge clk);
        #1 Rst = 1'b0;
        check("rst_we",   32'(mem_bus.mem_we),   32'h0);
        check("rst_addr", 32'(mem_bus.mem_addr), 32'h0);
        check("rst_din",  mem_bus.mem_din,       32'h0);
        check("rst_led",  32'(LED),              32'h0);
        check("rst_full", 32'(full),             32'h0);
        check("rst_err",  32'(err),              32'h0);

        // Table of clean four-byte words, written at consecutive addresses
        for (int v = 0; v < 4; v++) begin
            c0 = we_cnt;
            press_word(vecs[v].word);
            check("vec_we_pulses", 32'(we_cnt - c0),   32'd1);
            check("vec_we_addr",   32'(we_addr),       32'(vecs[v].exp_addr));
            check("vec_we_din",    we_din,             vecs[v].word);
            check("vec_led_after", 32'(LED),           32'(vecs[v].exp_led));
        end

        // Bouncing button: only the final long hold may capture
        do_reset(2);
        c0 = we_cnt;
        @(posedge clk); #1 Sw = 8'h77;
        repeat (5) begin
            Btn = 1'b1; repeat (3) @(posedge clk);
            #1 Btn = 1'b0; repeat (2) @(posedge clk);
            #1;
        end
        Btn = 1'b1; repeat (20) @(posedge clk);
        #1 Btn = 1'b0; repeat (10) @(posedge clk);
        #1;
        check("bounce_led", 32'(LED), 32'h40);
        check("bounce_no_write", 32'(we_cnt - c0), 32'd0);
        press_byte(8'h66); press_byte(8'h55); press_byte(8'h44);
        check("bounce_word", we_din, 32'h44556677);

        // Reset mid-word discards the partial bytes
        do_reset(2);
        press_byte(8'hAA); press_byte(8'hBB);
        check("partial_led", 32'(LED), 32'h80);
        do_reset(1);
        check("midreset_led", 32'(LED), 32'h00);
        c0 = we_cnt;
        press_word(32'h04030201);
        check("midreset_pulses", 32'(we_cnt - c0), 32'd1);
        check("midreset_addr", 32'(we_addr), 32'd0);
        check("midreset_din", we_din, 32'h04030201);

        // Reset lands on the same edge the press would capture
        press_byte(8'h99);
        c0 = we_cnt;
        @(posedge clk); #1 Sw = 8'h11; Btn = 1'b1;
        repeat (8) @(posedge clk);
        #1 Rst = 1'b1;
        @(posedge clk);
        #1 Rst = 1'b0; Btn = 1'b0;
        check("rstpress_led",  32'(LED),               32'h00);
        check("rstpress_addr", 32'(mem_bus.mem_addr),  32'h0);
        check("rstpress_din",  mem_bus.mem_din,        32'h0);
        check("rstpress_we",   32'(mem_bus.mem_we),    32'h0);
        check("rstpress_full", 32'(full),              32'h0);
        repeat (12) @(posedge clk);
        #1;
        check("rstpress_led_later", 32'(LED), 32'h00);
        check("rstpress_no_write", 32'(we_cnt - c0), 32'd0);

        // Fill all 64 words, then confirm further presses are dropped
        do_reset(2);
        c0 = we_cnt;
        for (int i = 0; i < 63; i++)
            press_word(32'hA5000000 + 32'(i));
        check("pre_full_flag", 32'(full), 32'h0);
        check("pre_full_led",  32'(LED),  32'h3F);
        press_word(32'hA500003F);
        check("full_flag",   32'(full),               32'h1);
        check("full_addr",   32'(mem_bus.mem_addr),   32'h0);
        check("full_writes", 32'(we_cnt - c0),        32'd64);
        check("full_last_addr", 32'(we_addr),         32'd63);
        check("full_last_din",  we_din,               32'hA500003F);
        c0 = we_cnt;
        press_word(32'h12345678);
        check("post_full_no_write", 32'(we_cnt - c0), 32'd0);
        check("post_full_led",      32'(LED),         32'h00);
        check("post_full_sticky",   32'(full),        32'h1);

`ifdef INST_LOADER_READBACK_EN
        do_reset(2);
        corrupt = 1'b1;
        press_word(32'h00100513);
        check("rb_err_set", 32'(err), 32'h1);
        corrupt = 1'b0;
        press_word(32'h12345678);
        check("rb_err_sticky", 32'(err), 32'h1);
        check("rb_led", 32'(LED), 32'h02);
        do_reset(2);
        press_word(32'h0BADF00D);
        check("rb_match_err", 32'(err), 32'h0);
        check("rb_match_led", 32'(LED), 32'h01);
`else
        do_reset(2);
        corrupt = 1'b1;
        press_word(32'h00100513);
        check("norb_err_tied", 32'(err), 32'h0);
        check("norb_led", 32'(LED), 32'h01);
        corrupt = 1'b0;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
